expr_sig_collector: RTL and testbench



---
 rtl/expr_sig_pkg.sv | 16 +
 rtl/expr_misr_step.sv | 22 ++
 rtl/expr_sig_collector.sv | 128 ++++++++++++
 tb/tb_expr_sig_collector.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/expr_sig_pkg.sv
// Shared types and constants for the expression-result signature collector.
// Y_W is the packed result-bus width produced by the expression modules.
package expr_sig_pkg;

  localparam int          Y_W      = 90;
  localparam logic [31:0] DEF_POLY = 32'h04C11DB7;
  localparam logic [31:0] DEF_SEED = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FOLD,
    ST_DONE
  } state_e;

endpackage

// File: rtl/expr_misr_step.sv
// Single combinational MISR step: shift left, conditionally apply the
// feedback polynomial, and fold in one zero-extended chunk.
module expr_misr_step
  import expr_sig_pkg::*;
#(
  parameter int               SIG_W   = 32,
  parameter int               CHUNK_W = 30,
  parameter logic [SIG_W-1:0] POLY    = SIG_W'(DEF_POLY)
) (
  input  logic [SIG_W-1:0]   sig_i,
  input  logic [CHUNK_W-1:0] chunk_i,
  output logic [SIG_W-1:0]   next_sig_o
);

  always_comb begin
    next_sig_o = {sig_i[SIG_W-2:0], 1'b0} ^ SIG_W'(chunk_i);
    if (sig_i[SIG_W-1]) begin
      next_sig_o = next_sig_o ^ POLY;
    end
  end

endmodule

// File: rtl/expr_sig_collector.sv
// Collects a programmed number of result vectors and folds them into a MISR
// signature. Optional comparator against exp_sig enabled by EXPR_SIG_CMP_EN.
module expr_sig_collector
  import expr_sig_pkg::*;
#(
  parameter int               Y_W     = expr_sig_pkg::Y_W,
  parameter int               CHUNK_W = 30,
  parameter int               SIG_W   = 32,
  parameter logic [SIG_W-1:0] POLY    = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED    = SIG_W'(DEF_SEED),
  parameter int               CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Y_W-1:0]   in_y,
  output logic             busy,
  output logic [CNT_W-1:0] vec_cnt,
  output logic             sig_valid,
  output logic [SIG_W-1:0] sig
`ifdef EXPR_SIG_CMP_EN
  ,
  input  logic [SIG_W-1:0] exp_sig,
  output logic             pass,
  output logic             fail
`endif
);

  localparam int NCHUNK = Y_W / CHUNK_W;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_e             state_q;
  logic [SIG_W-1:0]   sig_q;
  logic [SIG_W-1:0]   sig_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   target_q;
  logic [Y_W-1:0]     hold_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CHUNK_W-1:0] chunk;
  logic               last_chunk;

  // The holding register shifts up after each fold, so the next chunk is always on top.
  assign chunk      = hold_q[Y_W-1 -: CHUNK_W];
  assign last_chunk = (idx_q == IDX_W'(NCHUNK - 1));

  expr_misr_step #(
    .SIG_W  (SIG_W),
    .CHUNK_W(CHUNK_W),
    .POLY   (POLY)
  ) u_step (
    .sig_i     (sig_q),
    .chunk_i   (chunk),
    .next_sig_o(sig_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sig_q    <= SEED;
      cnt_q    <= '0;
      target_q <= '0;
      hold_q   <= '0;
      idx_q    <= '0;
`ifdef EXPR_SIG_CMP_EN
      pass     <= 1'b0;
      fail     <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            sig_q    <= SEED;
            cnt_q    <= '0;
            target_q <= num_vec;
            if (num_vec == '0) begin
              state_q <= ST_DONE;
`ifdef EXPR_SIG_CMP_EN
              pass    <= (SEED == exp_sig);
              fail    <= (SEED != exp_sig);
`endif
            end else begin
              state_q <= ST_RUN;
`ifdef EXPR_SIG_CMP_EN
              pass    <= 1'b0;
              fail    <= 1'b0;
`endif
            end
          end
        end
        ST_RUN: begin
          if (in_valid) begin
            hold_q  <= in_y;
            cnt_q   <= cnt_q + 1'b1;
            idx_q   <= '0;
            state_q <= ST_FOLD;
          end
        end
        ST_FOLD: begin
          sig_q  <= sig_d;
          hold_q <= hold_q << CHUNK_W;
          idx_q  <= idx_q + 1'b1;
          if (last_chunk) begin
            if (cnt_q == target_q) begin
              state_q <= ST_DONE;
`ifdef EXPR_SIG_CMP_EN
              pass    <= (sig_d == exp_sig);
              fail    <= (sig_d != exp_sig);
`endif
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_RUN);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_FOLD);
  assign sig_valid = (state_q == ST_DONE);
  assign sig       = sig_q;
  assign vec_cnt   = cnt_q;

endmodule

// File: tb/tb_expr_sig_collector.sv
// Randomized scoreboard bench for expr_sig_collector; pass/fail checks
// are included when EXPR_SIG_CMP_EN is defined.
module tb_expr_sig_collector;

  localparam logic [31:0] POLY_C = 32'h04C11DB7;
  localparam logic [31:0] SEED_C = 32'hFFFFFFFF;

  typedef struct packed {
    logic [31:0] sig;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] numVec;
  logic        inValid;
  logic        inReady;
  logic [89:0] inY;
  logic        busy;
  logic [15:0] vecCnt;
  logic        sigValid;
  logic [31:0] sig;
  logic [31:0] expSigIn;
  bit          corruptExp;
`ifdef EXPR_SIG_CMP_EN
  logic        pass;
  logic        fail;
`endif

  exp_t        expQ[$];
  logic [89:0] stimVecs[$];
  int          nCompared   = 0;
  int          nMismatched = 0;

  always #5 clk = ~clk;

  expr_sig_collector dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .num_vec  (numVec),
    .in_valid (inValid),
    .in_ready (inReady),
    .in_y     (inY),
    .busy     (busy),
    .vec_cnt  (vecCnt),
    .sig_valid(sigValid),
    .sig      (sig)
`ifdef EXPR_SIG_CMP_EN
    ,
    .exp_sig  (expSigIn),
    .pass     (pass),
    .fail     (fail)
`endif
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name);
    nCompared++;
    nMismatched++;
    $display("[TB] FAIL %s: bound expired", name);
  endtask

  // Reference signature computed straight from the folding rule over the stored vectors.
  function automatic logic [31:0] modelSig();
    logic [31:0] s;
    logic [29:0] ch;
    logic        carry;
    s = SEED_C;
    foreach (stimVecs[i]) begin
      for (int c = 0; c < 3; c++) begin
        ch    = 30'(stimVecs[i] >> (30 * (2 - c)));
        carry = s[31];
        s     = (s << 1) ^ {2'b00, ch};
        if (carry) s = s ^ POLY_C;
      end
    end
    return s;
  endfunction

  task automatic buildVectors(input int n, input bit zeroData);
    logic [95:0] raw;
    stimVecs.delete();
    for (int i = 0; i < n; i++) begin
      raw = {$urandom(), $urandom(), $urandom()};
      stimVecs.push_back(zeroData ? 90'd0 : raw[89:0]);
    end
  endtask

  task automatic applyStimulus(input bit gaps, input int abortAfter, input bit poke);
    int          n;
    int          idx;
    int          cyc;
    int          waitCyc;
    int          acceptCyc[$];
    bit          pokeNow;
    logic [95:0] raw;
    logic [31:0] expSig;
    n      = stimVecs.size();
    expSig = modelSig();
    expSigIn = corruptExp ? 32'd0 : expSig;
    if (abortAfter == 0) expQ.push_back('{sig: expSig, cnt: 16'(n)});
    start  = 1'b1;
    numVec = 16'(n);
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 2000) begin
      pokeNow = poke && (acceptCyc.size() > 0) &&
                (cyc == acceptCyc[0] + 1 || cyc == acceptCyc[0] + 4);
      start  = pokeNow;
      numVec = pokeNow ? 16'd1 : 16'(n);
      if (gaps && $urandom_range(0, 2) == 0) begin
        raw     = {$urandom(), $urandom(), $urandom()};
        inValid = 1'b0;
        inY     = raw[89:0];
      end else begin
        inValid = 1'b1;
        inY     = stimVecs[idx];
      end
      @(negedge clk);
      if (inValid && inReady) begin
        acceptCyc.push_back(cyc);
        idx++;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (pokeNow) checkOutput("vec_cnt after ignored start", 64'(vecCnt), 64'(idx));
      if (abortAfter > 0 && idx == abortAfter) begin
        inValid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("abort in_ready", 64'(inReady), 64'd0);
        checkOutput("abort busy", 64'(busy), 64'd0);
        checkOutput("abort sig_valid", 64'(sigValid), 64'd0);
        checkOutput("abort sig", 64'(sig), 64'(SEED_C));
        checkOutput("abort vec_cnt", 64'(vecCnt), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
    end
    inValid = 1'b0;
    if (idx < n) reportFail("accept timeout");
    if (!gaps) begin
      for (int k = 1; k < acceptCyc.size(); k++)
        checkOutput("accept spacing", 64'(acceptCyc[k] - acceptCyc[k-1]), 64'd4);
    end
    waitCyc = 0;
    @(negedge clk);
    while (!sigValid && waitCyc < 20) begin
      @(negedge clk);
      waitCyc++;
    end
    if (!sigValid) reportFail("sig_valid timeout");
    else checkOutput("sig_valid latency", 64'(waitCyc), (n == 0) ? 64'd0 : 64'd3);
    @(posedge clk); #1;
  endtask

  // Monitor: pops the expected result whenever the DUT raises sig_valid.
  initial begin : monitor
    logic prevValid;
    exp_t e;
    prevValid = 1'b0;
    forever begin
      @(negedge clk);
      if (sigValid && !prevValid) begin
        if (expQ.size() == 0) begin
          reportFail("unexpected sig_valid");
        end else begin
          e = expQ.pop_front();
          checkOutput("final sig", 64'(sig), 64'(e.sig));
          checkOutput("final vec_cnt", 64'(vecCnt), 64'(e.cnt));
`ifdef EXPR_SIG_CMP_EN
          checkOutput("pass", 64'(pass), 64'(expSigIn == e.sig));
          checkOutput("fail", 64'(fail), 64'(expSigIn != e.sig));
`endif
        end
      end
      prevValid = sigValid;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    rst        = 1'b1;
    start      = 1'b0;
    numVec     = 16'd0;
    inValid    = 1'b0;
    inY        = 90'd0;
    expSigIn   = 32'd0;
    corruptExp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset in_ready", 64'(inReady), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset sig_valid", 64'(sigValid), 64'd0);
    checkOutput("reset sig", 64'(sig), 64'(SEED_C));
    checkOutput("reset vec_cnt", 64'(vecCnt), 64'd0);
    @(posedge clk); #1;

    $display("[TB] empty run");
    buildVectors(0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("empty run sig", 64'(sig), 64'h0000_0000_FFFF_FFFF);

    $display("[TB] single zero vector");
    buildVectors(1, 1'b1);
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("zero vector sig", 64'(sig), 64'h0000_0000_E1B8_AFFD);
    checkOutput("zero vector vec_cnt", 64'(vecCnt), 64'd1);

    $display("[TB] four vectors, valid held high");
    buildVectors(4, 1'b0);
    applyStimulus(1'b0, 0, 1'b0);

    $display("[TB] reset during second fold, then rerun");
    buildVectors(5, 1'b0);
    applyStimulus(1'b0, 2, 1'b0);
    applyStimulus(1'b0, 0, 1'b0);

    $display("[TB] start pulses during RUN and FOLD");
    buildVectors(3, 1'b0);
    applyStimulus(1'b0, 0, 1'b1);

    $display("[TB] random runs with gaps");
    for (int r = 0; r < 5; r++) begin
      buildVectors($urandom_range(1, 6), 1'b0);
      applyStimulus(1'b1, 0, 1'b0);
    end

`ifdef EXPR_SIG_CMP_EN
    $display("[TB] comparator with wrong expectation");
    corruptExp = 1'b1;
    buildVectors(1, 1'b1);
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("fail with exp_sig 0", 64'(fail), 64'd1);
    corruptExp = 1'b0;
`endif

    repeat (3) @(posedge clk);
    checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
